// File: rtl/cpu_pc_stack_reg_if.sv
// cpu_pc_stack_reg_if
// Bus between the control unit and the program-counter register.
//   master : control unit; drives d and the load/inc/call/ret/hold strobes,
//            and observes the PC, stack occupancy and status flags.
//   slave  : the PC register itself.
// Parameters N (PC width) and DEPTH (return-stack entries) must match the
// cpu_pc_stack_reg instance this interface is connected to.
interface cpu_pc_stack_reg_if #(
    parameter int N     = 8,
    parameter int DEPTH = 4
);
    localparam int SP_W = $clog2(DEPTH + 1);

    logic [N-1:0]    d;
    logic            load;
    logic            inc;
    logic            call;
    logic            ret;
    logic            hold;
    logic [N-1:0]    q;
    logic [SP_W-1:0] sp;
    logic            full;
    logic            empty;
    logic            wrap;
    logic            conflict;
    logic            ovf_err;
    logic            unf_err;

    modport master (
        output d, load, inc, call, ret, hold,
        input  q, sp, full, empty, wrap, conflict, ovf_err, unf_err
    );

    modport slave (
        input  d, load, inc, call, ret, hold,
        output q, sp, full, empty, wrap, conflict, ovf_err, unf_err
    );
endinterface

// File: rtl/cpu_pc_stack_reg.sv
// cpu_pc_stack_reg
// Program-counter register for the fetch path, with a configurable increment
// step, a DEPTH-entry call/return stack, a stall input, wrap detection and
// sticky stack error flags.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset (overrides hold and all strobes)
//   bus  : cpu_pc_stack_reg_if.slave
//          in : d, load, inc, call, ret, hold
//          out: q (PC), sp (occupancy 0..DEPTH), full, empty,
//               wrap / conflict (one-cycle pulses), ovf_err / unf_err (sticky)
module cpu_pc_stack_reg #(
    parameter int           N       = 8,
    parameter int           DEPTH   = 4,
    parameter int           STEP    = 1,
    parameter logic [N-1:0] RST_VAL = '0
) (
    input logic               clk,
    input logic               rst,
    cpu_pc_stack_reg_if.slave bus
);
    localparam int              SP_W   = $clog2(DEPTH + 1);
    localparam int              AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [N:0]      STEP_X = (N + 1)'(STEP);
    localparam logic [SP_W-1:0] SP_MAX = SP_W'(DEPTH);
    localparam logic [SP_W-1:0] SP_ONE = SP_W'(1);

    logic [N-1:0]    stack [DEPTH];
    logic [N-1:0]    q_r;
    logic [SP_W-1:0] sp_r;
    logic            wrap_r;
    logic            conflict_r;
    logic            ovf_r;
    logic            unf_r;

    logic [N:0]      next_seq;   // {carry, q + STEP}
    logic            full;
    logic            empty;
    logic            multi;
    logic            push;
    logic [AW-1:0]   wr_idx;
    logic [AW-1:0]   rd_idx;

    always_comb begin
        next_seq = {1'b0, q_r} + STEP_X;
        full     = (sp_r == SP_MAX);
        empty    = (sp_r == '0);
        multi    = ($countones({bus.load, bus.inc, bus.call, bus.ret}) > 1);
        push     = !rst && !bus.hold && !multi && bus.call && !full;
        // Entries 0..DEPTH-1; sp itself needs one extra bit to represent DEPTH.
        wr_idx   = AW'(sp_r);
        rd_idx   = AW'(sp_r - SP_ONE);
    end

    // ---- return stack storage (not cleared by reset) ----
    always_ff @(posedge clk) begin
        if (push) begin
            stack[wr_idx] <= next_seq[N-1:0];
        end
    end

    // ---- PC, stack pointer and status flags ----
    always_ff @(posedge clk) begin
        if (rst) begin
            q_r        <= RST_VAL;
            sp_r       <= '0;
            wrap_r     <= 1'b0;
            conflict_r <= 1'b0;
            ovf_r      <= 1'b0;
            unf_r      <= 1'b0;
        end else begin
            wrap_r     <= 1'b0;
            conflict_r <= 1'b0;
            if (!bus.hold) begin
                if (multi) begin
                    conflict_r <= 1'b1;
                end else if (bus.load) begin
                    q_r <= bus.d;
                end else if (bus.inc) begin
                    q_r    <= next_seq[N-1:0];
                    wrap_r <= next_seq[N];
                end else if (bus.call) begin
                    if (full) begin
                        ovf_r <= 1'b1;
                    end else begin
                        q_r    <= bus.d;
                        sp_r   <= sp_r + SP_ONE;
                        wrap_r <= next_seq[N];
                    end
                end else if (bus.ret) begin
                    if (empty) begin
                        unf_r <= 1'b1;
                    end else begin
                        q_r  <= stack[rd_idx];
                        sp_r <= sp_r - SP_ONE;
                    end
                end
            end
        end
    end

    assign bus.q        = q_r;
    assign bus.sp       = sp_r;
    assign bus.full     = full;
    assign bus.empty    = empty;
    assign bus.wrap     = wrap_r;
    assign bus.conflict = conflict_r;
    assign bus.ovf_err  = ovf_r;
    assign bus.unf_err  = unf_r;
endmodule

// File: doc/cpu_pc_stack_reg.md
Name: cpu_pc_stack_reg

Overview:
- Parametrised program-counter register, the clocked successor to the team's N-bit load/inc latch.
- Adds a configurable increment step, a call/return stack of DEPTH entries, a hold/stall input, wrap detection, and sticky error flags.
- Sits in the CPU fetch path.
- Control unit drives the strobes; q addresses instruction memory.

Parameters:
- N, 8, width of q, d and each stack entry.
- DEPTH, 4, return-stack entries (>=1).
- STEP, 1, increment amount applied by inc and used for the call return address (1 <= STEP < 2^N).
- RST_VAL, 0, value q takes on reset (N bits).

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  synchronous active-high reset.
- d  input  N  jump/call target.
- load  input  1  jump: q <= d.
- inc  input  1  q <= q + STEP.
- call  input  1  push q+STEP, then q <= d.
- ret  input  1  pop stack into q.
- hold  input  1  stall; freezes all state.
- q  output  N  current PC.
- sp  output  $clog2(DEPTH+1)  stack occupancy, 0..DEPTH.
- full  output  1  sp == DEPTH (combinational from sp).
- empty  output  1  sp == 0 (combinational from sp).
- wrap  output  1  one-cycle pulse: the last inc or call return-address computation overflowed 2^N.
- conflict  output  1  one-cycle pulse: more than one of load/inc/call/ret was sampled.
- ovf_err  output  1  sticky: call attempted while full.
- unf_err  output  1  sticky: ret attempted while empty.

Behaviour:
- All state updates on the rising clk edge only. No latches, no asynchronous paths.
- Registered outputs change one cycle after the strobe is sampled.
- Priority order: rst > hold > operation decode.
- rst=1 sets:
  - q=RST_VAL, sp=0.
  - wrap=0, conflict=0, ovf_err=0, unf_err=0.
  - Stack RAM contents are not cleared.
  - rst overrides hold and every strobe in the same cycle.
  - rst asserted mid-sequence (for example between consecutive calls) discards the stack: sp=0.
- hold=1 (rst=0):
  - q, sp, the stack and the sticky flags are unchanged.
  - wrap=0 and conflict=0 that cycle.
  - Strobes are ignored, not queued.
- Operation decode (rst=0, hold=0); count the asserted strobes among load, inc, call, ret:
  - 0 asserted: idle. All state holds; pulses 0.
  - More than 1 asserted: no state change, conflict=1 for one cycle. This includes load+inc, which the previous generation silently ignored.
  - load: q <= d.
  - inc: q <= (q + STEP) mod 2^N. wrap=1 iff q + STEP >= 2^N. Example: N=8, STEP=1, q=0xFF gives q=0x00 and wrap=1.
  - call, not full:
    - stack[sp] <= (q + STEP) mod 2^N.
    - sp <= sp+1, q <= d.
    - wrap=1 iff q + STEP >= 2^N.
  - call, full: q and sp unchanged, no write, ovf_err <= 1.
  - ret, not empty: q <= stack[sp-1], sp <= sp-1.
  - ret, empty: q and sp unchanged, unf_err <= 1.
- ovf_err and unf_err stay set until rst; hold and further operations do not clear them.
- A ret in the cycle immediately after a call returns the value that call pushed (write-then-read at sequential edges, no bypass needed).
- sp never exceeds DEPTH and never goes below 0 under any stimulus.
- Arithmetic is N-bit unsigned. The carry-out of the add drives wrap only.

Test Plan:
- Reset/idle: N=8, RST_VAL=0x10. Assert rst for 1 cycle with inc=1 -> q=0x10, sp=0, all flags 0. Three idle cycles -> q stays 0x10.
- Increment and wrap: STEP=1, load d=0xFE, then inc for 3 cycles -> q=0xFF, 0x00, 0x01. wrap pulses only on the 0xFF->0x00 edge. Repeat with STEP=4 from q=0xFC -> q=0x00, wrap=1.
- Call/return nesting (DEPTH=4):
  - From q=0x20, call d=0x80 -> q=0x80, sp=1.
  - call d=0x90 -> q=0x90, sp=2.
  - ret -> q=0x81, sp=1.
  - ret -> q=0x21, sp=0, empty=1.
- Stack limits:
  - 4 calls -> full=1.
  - 5th call d=0xAA -> q unchanged, sp=4, ovf_err=1, sticky across 10 cycles.
  - After rst, 2 rets -> q=RST_VAL, unf_err=1.
- Conflict and hold:
  - load=1 and inc=1 with q=0x40 -> q=0x40, conflict=1 for one cycle.
  - hold=1 with call=1 -> q, sp unchanged, conflict=0.
  - hold=1 with rst=1 -> reset wins.
- Reset mid-operation: 3 calls (sp=3), then rst with ret=1 -> sp=0, q=RST_VAL, ovf_err=0, unf_err=0. Next ret -> unf_err=1.
